hsid_x_obi_result_wb: RTL and testbench
=======================================

Name: hsid_x_obi_result_wb

Overview:
- OBI master write-back stage directly downstream of hsid_main.
- On a start pulse (driven by the hsid_main done strobe, or by a register-triggered copy of it), it captures the four MSE result fields.
- It writes them as four consecutive 32-bit words to a software-programmed result buffer, so the host can read results from memory instead of polling registers.
- It shares the OBI master port with the read path through an external arbiter.

Parameters:
- WORD_WIDTH, HSID_WORD_WIDTH (32), OBI data/address width in bits.
- HSP_LIBRARY_WIDTH, HSID_HSP_LIBRARY_WIDTH, width of the min/max pixel reference fields.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle request to write back results
- clear  in  1  abort request
- result_addr  in  WORD_WIDTH  byte base address of result buffer; must be word aligned
- mse_min_ref  in  HSP_LIBRARY_WIDTH  library index of minimum MSE
- mse_min_value  in  WORD_WIDTH  minimum MSE
- mse_max_ref  in  HSP_LIBRARY_WIDTH  library index of maximum MSE
- mse_max_value  in  WORD_WIDTH  maximum MSE
- obi_req  out  1  OBI request
- obi_gnt  in  1  OBI grant
- obi_addr  out  WORD_WIDTH  OBI byte address
- obi_we  out  1  write enable; always 1 while obi_req is high
- obi_be  out  4  byte enables; always 4'hF
- obi_wdata  out  WORD_WIDTH  write data
- obi_rvalid  in  1  OBI response valid
- obi_err  in  1  OBI response error, sampled with obi_rvalid
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse when all 4 words have been acknowledged
- error  out  1  one-cycle pulse on misaligned address or bus error

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; all outputs 0; word counter 0; capture registers 0.
- Word layout, offsets from result_addr:
  - +0x0 mse_min_value
  - +0x4 mse_min_ref, zero-extended
  - +0x8 mse_max_value
  - +0xC mse_max_ref, zero-extended
- Address arithmetic: result_addr + {idx,2'b00} is computed modulo 2^WORD_WIDTH; wrap-around is allowed.
- States: IDLE, REQ, RSP, FINISH.
- IDLE:
  - start=1 with result_addr[1:0]==0: capture all four fields and result_addr, set idx=0, go to REQ.
  - start=1 with result_addr[1:0]!=0: pulse error next cycle, stay IDLE, issue no OBI traffic.
  - clear has no effect in IDLE.
- REQ:
  - obi_req=1, with addr, wdata and we stable until obi_gnt.
  - On gnt go to RSP; obi_req drops the cycle after gnt.
  - Only one transaction is outstanding at a time.
- RSP: wait for obi_rvalid.
  - rvalid with obi_err=1: pulse error, go to IDLE, no done.
  - rvalid with idx==3: go to FINISH.
  - Otherwise: idx++, go to REQ.
- FINISH: done=1 for one cycle, then IDLE.
- busy=1 in REQ, RSP and FINISH.
- Latency:
  - Cycle N: start. Cycle N+1: first obi_req.
  - With zero-wait gnt and rvalid one cycle after gnt, each word takes 2 cycles.
  - done is high in cycle N+9.
- start while busy: ignored; captured values are not disturbed.
- clear:
  - In REQ: the request is not retracted (OBI rule). The module completes gnt and then rvalid, and returns to IDLE with no done and no error.
  - In RSP: the module waits for rvalid, then goes to IDLE.
  - In FINISH: done is suppressed, go to IDLE.
  - clear and start in the same IDLE cycle: start wins.
- Reset mid-transfer: immediate return to IDLE, outputs 0. Bus-side recovery is the arbiter's responsibility.

Decomposition:
- hsid_pkg additions:
  - HSID_RESULT_WORDS = 4
  - the result offset constants
  - typedef enum hsid_wb_state_t {IDLE, REQ, RSP, FINISH}
- Single module; no sub-module. A separate address/data mux is not warranted.

Test Plan:
- result_addr=0x1000; min_value=0x25, min_ref=3, max_value=0xFFFF, max_ref=7; gnt always 1, rvalid 1 cycle later -> writes to 0x1000/1004/1008/100C carry data 0x25/3/0xFFFF/7; be=F; done pulses in cycle start+9; busy falls with done.
- Same transfer with gnt delayed 3 cycles on word 1 -> obi_addr=0x1004 and obi_wdata=3 held stable for all 4 req cycles; done still occurs exactly once.
- result_addr=0x1002 with start -> error pulse next cycle; obi_req never asserts; busy stays 0.
- obi_err=1 on word 2 -> error pulse; no done; no request to 0x100C.
- clear asserted during REQ of word 1 with gnt delayed 2 cycles -> that word completes; no further req; no done; IDLE reached.
- start pulsed again mid-transfer with different input values -> ignored; written data matches the first capture.
- result_addr=0xFFFFFFF8 -> addresses FFFFFFF8, FFFFFFFC, 0, 4 are written.

Source files
------------

// File: rtl/hsid_x_obi_result_wb_pkg.sv
// Shared constants and types for the hsid result write-back stage.
package hsid_x_obi_result_wb_pkg;

    localparam int HSID_WORD_WIDTH        = 32;
    localparam int HSID_HSP_LIBRARY_WIDTH = 8;
    localparam int HSID_RESULT_WORDS      = 4;

    // Byte offsets of each result word from the programmed base address
    localparam logic [3:0] HSID_OFF_MIN_VALUE = 4'h0;
    localparam logic [3:0] HSID_OFF_MIN_REF   = 4'h4;
    localparam logic [3:0] HSID_OFF_MAX_VALUE = 4'h8;
    localparam logic [3:0] HSID_OFF_MAX_REF   = 4'hC;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RSP,
        FINISH
    } hsid_wb_state_t;

    function automatic logic [3:0] result_offset(input logic [1:0] idx);
        logic [3:0] off;
        case (idx)
            2'd0:    off = HSID_OFF_MIN_VALUE;
            2'd1:    off = HSID_OFF_MIN_REF;
            2'd2:    off = HSID_OFF_MAX_VALUE;
            default: off = HSID_OFF_MAX_REF;
        endcase
        return off;
    endfunction

endpackage

// File: rtl/hsid_x_obi_result_wb_if.sv
// OBI write-only master bus bundle used by the result write-back stage.
interface hsid_x_obi_result_wb_if #(
    parameter int WORD_WIDTH = 32
);
    logic                  req;
    logic                  gnt;
    logic [WORD_WIDTH-1:0] addr;
    logic                  we;
    logic [3:0]            be;
    logic [WORD_WIDTH-1:0] wdata;
    logic                  rvalid;
    logic                  err;

    modport master (output req, addr, we, be, wdata, input gnt, rvalid, err);
    modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, err);
endinterface

// File: rtl/hsid_x_obi_result_wb.sv
// Writes the four MSE result fields as consecutive words to a result buffer
// over OBI, one outstanding transaction at a time.
module hsid_x_obi_result_wb
    import hsid_x_obi_result_wb_pkg::*;
#(
    parameter int WORD_WIDTH        = HSID_WORD_WIDTH,
    parameter int HSP_LIBRARY_WIDTH = HSID_HSP_LIBRARY_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         clear,
    input  logic [WORD_WIDTH-1:0]        result_addr,
    input  logic [HSP_LIBRARY_WIDTH-1:0] mse_min_ref,
    input  logic [WORD_WIDTH-1:0]        mse_min_value,
    input  logic [HSP_LIBRARY_WIDTH-1:0] mse_max_ref,
    input  logic [WORD_WIDTH-1:0]        mse_max_value,
    hsid_x_obi_result_wb_if.master       obi,
    output logic                         busy,
    output logic                         done,
    output logic                         error
);

    hsid_wb_state_t               state;
    logic [1:0]                   idx;
    logic [WORD_WIDTH-1:0]        base_q;
    logic [HSP_LIBRARY_WIDTH-1:0] min_ref_q, max_ref_q;
    logic [WORD_WIDTH-1:0]        min_value_q, max_value_q;
    logic                         req_q;
    logic [WORD_WIDTH-1:0]        addr_q, wdata_q;
    logic                         done_q;
    logic                         abort_q;
    logic [1:0]                   nidx;

    assign nidx = idx + 2'd1;

    function automatic logic [WORD_WIDTH-1:0] word_data(input logic [1:0] i);
        logic [WORD_WIDTH-1:0] d;
        case (i)
            2'd0:    d = min_value_q;
            2'd1:    d = WORD_WIDTH'(min_ref_q);
            2'd2:    d = max_value_q;
            default: d = WORD_WIDTH'(max_ref_q);
        endcase
        return d;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            base_q      <= '0;
            min_ref_q   <= '0;
            max_ref_q   <= '0;
            min_value_q <= '0;
            max_value_q <= '0;
            req_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            busy        <= 1'b0;
            done_q      <= 1'b0;
            error       <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            error  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (result_addr[1:0] == 2'b00) begin
                            base_q      <= result_addr;
                            min_ref_q   <= mse_min_ref;
                            max_ref_q   <= mse_max_ref;
                            min_value_q <= mse_min_value;
                            max_value_q <= mse_max_value;
                            idx         <= '0;
                            addr_q      <= result_addr;
                            wdata_q     <= mse_min_value;
                            req_q       <= 1'b1;
                            busy        <= 1'b1;
                            abort_q     <= 1'b0;
                            state       <= REQ;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                // An issued request cannot be retracted; clear only takes
                // effect once the current word's response has returned.
                REQ: begin
                    if (clear) abort_q <= 1'b1;
                    if (obi.gnt) begin
                        req_q <= 1'b0;
                        state <= RSP;
                    end
                end
                RSP: begin
                    if (clear) abort_q <= 1'b1;
                    if (obi.rvalid) begin
                        if (obi.err) begin
                            error <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else if (abort_q || clear) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else if (idx == 2'(HSID_RESULT_WORDS - 1)) begin
                            done_q <= 1'b1;
                            state  <= FINISH;
                        end else begin
                            idx     <= nidx;
                            addr_q  <= base_q + WORD_WIDTH'(result_offset(nidx));
                            wdata_q <= word_data(nidx);
                            req_q   <= 1'b1;
                            state   <= REQ;
                        end
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // clear arriving in the FINISH cycle itself must still cancel done
    assign done = done_q & ~clear;

    assign obi.req   = req_q;
    assign obi.we    = req_q;
    assign obi.be    = {4{req_q}};
    assign obi.addr  = addr_q;
    assign obi.wdata = wdata_q;

endmodule

// File: tb/tb_hsid_x_obi_result_wb.sv
// Directed bench for hsid_x_obi_result_wb with a scripted OBI slave.
module tb_hsid_x_obi_result_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, clear;
    logic [31:0] result_addr;
    logic [7:0]  mse_min_ref, mse_max_ref;
    logic [31:0] mse_min_value, mse_max_value;
    logic        busy, done, error;

    hsid_x_obi_result_wb_if #(.WORD_WIDTH(32)) bus ();

    hsid_x_obi_result_wb #(.WORD_WIDTH(32), .HSP_LIBRARY_WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .clear        (clear),
        .result_addr  (result_addr),
        .mse_min_ref  (mse_min_ref),
        .mse_min_value(mse_min_value),
        .mse_max_ref  (mse_max_ref),
        .mse_max_value(mse_max_value),
        .obi          (bus),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // slave configuration and observations
    int          gdelay[4];
    int          err_word;
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    logic [3:0]  log_be[$];
    int          reqc[4];
    int          nreq_total, hold_bad, ngrant, nresp;

    // monitor observations
    int   ndone, nerr, done_cyc, err_cyc;
    logic busy_seen, busy_at_done, busy_after_done;

    initial begin
        logic [31:0] h_addr, h_data;
        logic        pend;
        int          waitc;
        bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.err = 1'b0;
        pend = 1'b0; waitc = 0; h_addr = '0; h_data = '0;
        forever begin
            @(negedge clk);
            bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.err = 1'b0;
            if (rst) begin
                pend = 1'b0; waitc = 0;
            end else if (pend) begin
                bus.rvalid = 1'b1;
                bus.err    = (nresp == err_word);
                nresp++;
                pend = 1'b0;
            end else if (bus.req) begin
                nreq_total++;
                if (ngrant < 4) reqc[ngrant]++;
                if (waitc == 0) begin
                    h_addr = bus.addr; h_data = bus.wdata;
                end else if (bus.addr !== h_addr || bus.wdata !== h_data || bus.we !== 1'b1) begin
                    hold_bad++;
                end
                if (waitc >= gdelay[ngrant & 3]) begin
                    bus.gnt = 1'b1;
                    log_addr.push_back(bus.addr);
                    log_data.push_back(bus.wdata);
                    log_be.push_back(bus.be);
                    ngrant++;
                    pend = 1'b1;
                    waitc = 0;
                end else begin
                    waitc++;
                end
            end
        end
    end

    initial begin
        logic prev_done;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_done) busy_after_done = busy;
            if (done) begin ndone++; done_cyc = cyc; busy_at_done = busy; end
            if (error) begin nerr++; err_cyc = cyc; end
            if (busy) busy_seen = 1'b1;
            prev_done = done;
        end
    end

    task automatic reset_obs();
        log_addr.delete(); log_data.delete(); log_be.delete();
        for (int i = 0; i < 4; i++) begin reqc[i] = 0; gdelay[i] = 0; end
        nreq_total = 0; hold_bad = 0; ngrant = 0; nresp = 0; err_word = -1;
        ndone = 0; nerr = 0; done_cyc = -1; err_cyc = -1;
        busy_seen = 1'b0; busy_at_done = 1'b0; busy_after_done = 1'b1;
    endtask

    // Start a transfer, optionally pulsing clear or a second start k cycles later.
    task automatic run(input logic [31:0] a, input int clr_at, input int rs_at, output int t0);
        @(negedge clk);
        result_addr   = a;
        mse_min_value = 32'h25;  mse_min_ref = 8'd3;
        mse_max_value = 32'hFFFF; mse_max_ref = 8'd7;
        start = 1'b1;
        t0 = cyc;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            start = (k == rs_at);
            clear = (k == clr_at);
            if (k == rs_at) begin
                result_addr   = 32'h2000;
                mse_min_value = 32'hDEAD; mse_min_ref = 8'hAA;
                mse_max_value = 32'hBEEF; mse_max_ref = 8'h55;
            end
        end
        start = 1'b0; clear = 1'b0;
    endtask

    initial begin
        int t0;
        logic [31:0] ea[4];
        logic [31:0] ed[4];
        rst = 1'b1; start = 1'b0; clear = 1'b0; result_addr = '0;
        mse_min_ref = '0; mse_max_ref = '0; mse_min_value = '0; mse_max_value = '0;
        reset_obs();
        repeat (3) @(negedge clk);
        chk("rst_req",   {31'b0, bus.req}, 32'd0);
        chk("rst_we",    {31'b0, bus.we}, 32'd0);
        chk("rst_be",    {28'b0, bus.be}, 32'd0);
        chk("rst_addr",  bus.addr, 32'd0);
        chk("rst_wdata", bus.wdata, 32'd0);
        chk("rst_flags", {29'b0, busy, done, error}, 32'd0);
        rst = 1'b0;

        ed[0] = 32'h25; ed[1] = 32'd3; ed[2] = 32'hFFFF; ed[3] = 32'd7;

        // 1: zero-wait transfer
        reset_obs();
        run(32'h1000, -1, -1, t0);
        chk("t1_nwr", log_addr.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < log_addr.size()) begin
                chk($sformatf("t1_addr%0d", i), log_addr[i], 32'h1000 + 32'(4 * i));
                chk($sformatf("t1_data%0d", i), log_data[i], ed[i]);
                chk($sformatf("t1_be%0d", i), {28'b0, log_be[i]}, 32'hF);
            end
        end
        chk("t1_done_lat", done_cyc - t0, 9);
        chk("t1_ndone", ndone, 1);
        chk("t1_nerr", nerr, 0);
        chk("t1_busy_at_done", {31'b0, busy_at_done}, 1);
        chk("t1_busy_after", {31'b0, busy_after_done}, 0);

        // 2: grant delayed 3 cycles on word 1
        reset_obs();
        gdelay[1] = 3;
        run(32'h1000, -1, -1, t0);
        chk("t2_nwr", log_addr.size(), 4);
        if (log_addr.size() > 1) begin
            chk("t2_addr1", log_addr[1], 32'h1004);
            chk("t2_data1", log_data[1], 32'd3);
        end
        chk("t2_reqc1", reqc[1], 4);
        chk("t2_hold", hold_bad, 0);
        chk("t2_ndone", ndone, 1);
        chk("t2_done_lat", done_cyc - t0, 12);

        // 3: misaligned base address
        reset_obs();
        run(32'h1002, -1, -1, t0);
        chk("t3_nerr", nerr, 1);
        chk("t3_err_lat", err_cyc - t0, 1);
        chk("t3_nreq", nreq_total, 0);
        chk("t3_busy", {31'b0, busy_seen}, 0);
        chk("t3_ndone", ndone, 0);

        // 4: bus error on word 2
        reset_obs();
        err_word = 2;
        run(32'h1000, -1, -1, t0);
        chk("t4_nerr", nerr, 1);
        chk("t4_ndone", ndone, 0);
        chk("t4_nwr", log_addr.size(), 3);
        chk("t4_busy_end", {31'b0, busy}, 0);

        // 5: clear during REQ of word 1, grant delayed 2
        reset_obs();
        gdelay[1] = 2;
        run(32'h1000, 3, -1, t0);
        chk("t5_nwr", log_addr.size(), 2);
        chk("t5_reqc1", reqc[1], 3);
        chk("t5_nreq", nreq_total, 4);
        chk("t5_ndone", ndone, 0);
        chk("t5_nerr", nerr, 0);
        chk("t5_busy_end", {31'b0, busy}, 0);

        // 6: second start mid-transfer is ignored
        reset_obs();
        run(32'h1000, -1, 4, t0);
        chk("t6_nwr", log_addr.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < log_addr.size()) begin
                chk($sformatf("t6_addr%0d", i), log_addr[i], 32'h1000 + 32'(4 * i));
                chk($sformatf("t6_data%0d", i), log_data[i], ed[i]);
            end
        end
        chk("t6_ndone", ndone, 1);

        // 7: address wrap-around
        reset_obs();
        ea[0] = 32'hFFFFFFF8; ea[1] = 32'hFFFFFFFC; ea[2] = 32'h0; ea[3] = 32'h4;
        run(32'hFFFFFFF8, -1, -1, t0);
        chk("t7_nwr", log_addr.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < log_addr.size()) chk($sformatf("t7_addr%0d", i), log_addr[i], ea[i]);
        chk("t7_ndone", ndone, 1);

        // 8: reset mid-transfer
        reset_obs();
        @(negedge clk);
        result_addr = 32'h3000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t8_req", {31'b0, bus.req}, 0);
        chk("t8_busy", {31'b0, busy}, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
